// File: rtl/gray_arb_pkg.sv
// Shared encodings for the Gray step arbiter: FSM state values and the Gray wrap marker.
package gray_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Last code of the 3-bit Gray sequence; stepping out of it wraps to 000.
    localparam logic [2:0] GRAY_LAST = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/gray_step_counter.sv
// Free-running binary counter with a registered Gray view and a one-cycle wrap pulse Y.
module gray_step_counter
    import gray_arb_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             I,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] gray,
    output logic             Y
);

    // Gray code of the all-ones binary value: 100 for the 3-bit counter.
    localparam logic [WIDTH-1:0] WRAP_GRAY = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] bin_nxt;

    assign bin_nxt = bin + 1'b1;

    always_ff @(posedge I or posedge reset) begin
        if (reset) begin
            bin  <= '0;
            gray <= '0;
            Y    <= 1'b0;
        end else begin
            Y <= en && (gray == WRAP_GRAY);
            if (en) begin
                bin  <= bin_nxt;
                gray <= bin_nxt ^ (bin_nxt >> 1);
            end
        end
    end

endmodule

// File: rtl/gray_step_arbiter.sv
// Round-robin arbiter handing a shared Gray step counter to one of two requesters for N steps.
// Optional GRAY_ARB_PAUSE_EN adds a `pause` input that freezes stepping while in RUN.
module gray_step_arbiter
    import gray_arb_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = 4
) (
    input  logic             I,
    input  logic             reset,
    input  logic             req0,
    input  logic [CNT_W-1:0] len0,
    input  logic             req1,
    input  logic [CNT_W-1:0] len1,
`ifdef GRAY_ARB_PAUSE_EN
    input  logic             pause,
`endif
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gray,
    output logic             Y
);

    state_t           state;
    logic             last;
    logic [CNT_W-1:0] rem;
    logic             step_en;
    logic             pick1;
    logic [CNT_W-1:0] pick_len;

`ifdef GRAY_ARB_PAUSE_EN
    assign step_en = (state == S_RUN) && !pause;
`else
    assign step_en = (state == S_RUN);
`endif

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign pick1    = req1 && (!req0 || !last);
    assign pick_len = pick1 ? len1 : len0;

    always_ff @(posedge I or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            last  <= 1'b1;
            rem   <= '0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        gnt0 <= !pick1;
                        gnt1 <= pick1;
                        last <= pick1;
                        rem  <= pick_len;
                        busy <= 1'b1;
                        if (pick_len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // done rises on the same edge as the final step.
                    if (step_en && rem != '0) begin
                        rem <= rem - 1'b1;
                        if (rem == CNT_W'(1)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    gray_step_counter #(.WIDTH(WIDTH)) u_cnt (
        .I     (I),
        .reset (reset),
        .en    (step_en),
        .gray  (gray),
        .Y     (Y)
    );

endmodule
